timestamp_capture_multi: RTL and testbench

- Parametrised successor to the single-pair latch counter.
- One free-running synchronous counter is shared by pCHANNELS independent capture channels.
- Each channel synchronises an asynchronous event line, captures the count on the rising edge, and holds it until the host acknowledges.
- Sits between the event inputs (buttons, external triggers) and the USB/JTAG readout logic; a lowest-index-first read port lets the host drain the channels serially.

---
 rtl/timestamp_capture_multi.sv | 129 ++++++++++++
 tb/tb_timestamp_capture_multi.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timestamp_capture_multi.sv
// Shared free-running counter with pCHANNELS independent event-capture channels.
// Each channel synchronises its event line, latches the count on a rising edge and holds it until acknowledged.
module timestamp_capture_multi #(
  parameter int pCHANNELS = 4,
  parameter int pWIDTH    = 64,
  parameter int pSYNC     = 2,
  localparam int SELW     = (pCHANNELS > 1) ? $clog2(pCHANNELS) : 1
) (
  input  logic                          iCLKd,
  input  logic                          rstA,
  input  logic                          iEnable,
  input  logic                          iClear,
  input  logic [pCHANNELS-1:0]          iLatch,
  input  logic [pCHANNELS-1:0]          iAck,
  output logic [pWIDTH-1:0]             oCount,
  output logic [pCHANNELS-1:0]          oReady,
  output logic [pCHANNELS-1:0]          oOverrun,
  output logic [pCHANNELS*pWIDTH-1:0]   oData,
  output logic                          oSelValid,
  output logic [SELW-1:0]               oSel,
  output logic [pWIDTH-1:0]             oSelData
);

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  logic [pWIDTH-1:0]           count_q, count_d;
  logic [pCHANNELS-1:0]        sync_q [pSYNC];
  logic [pCHANNELS-1:0]        sync_d [pSYNC];
  logic [pCHANNELS-1:0]        hist_q, hist_d;
  logic [pCHANNELS-1:0]        overrun_q, overrun_d;
  logic [pCHANNELS*pWIDTH-1:0] data_q, data_d;
  state_t                      state_q [pCHANNELS];
  state_t                      state_d [pCHANNELS];

  logic [pCHANNELS-1:0]        edge_det;
  logic [pCHANNELS-1:0]        ready;
  logic                        sel_valid;
  logic [SELW-1:0]             sel_idx;

  always_ff @(posedge iCLKd or posedge rstA) begin
    if (rstA) begin
      count_q   <= '0;
      hist_q    <= '0;
      overrun_q <= '0;
      data_q    <= '0;
      for (int k = 0; k < pSYNC; k++) sync_q[k] <= '0;
      for (int i = 0; i < pCHANNELS; i++) state_q[i] <= IDLE;
    end else begin
      count_q   <= count_d;
      hist_q    <= hist_d;
      overrun_q <= overrun_d;
      data_q    <= data_d;
      for (int k = 0; k < pSYNC; k++) sync_q[k] <= sync_d[k];
      for (int i = 0; i < pCHANNELS; i++) state_q[i] <= state_d[i];
    end
  end

  // Clear wins over increment; the counter wraps naturally at all-ones.
  always_comb begin
    count_d = count_q;
    if (iClear) begin
      count_d = '0;
    end else if (iEnable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < pSYNC; k++) sync_d[k] = '0;
    sync_d[0] = iLatch;
    for (int k = 1; k < pSYNC; k++) sync_d[k] = sync_q[k-1];
    hist_d   = sync_q[pSYNC-1];
    edge_det = sync_q[pSYNC-1] & ~hist_q;
  end

  // An edge coinciding with an ack re-arms with the fresh count so no event is dropped.
  always_comb begin
    overrun_d = overrun_q;
    data_d    = data_q;
    for (int i = 0; i < pCHANNELS; i++) state_d[i] = state_q[i];
    for (int i = 0; i < pCHANNELS; i++) begin
      case (state_q[i])
        IDLE: begin
          if (edge_det[i]) begin
            state_d[i]                    = HELD;
            data_d[i*pWIDTH +: pWIDTH]    = count_q;
          end
        end
        HELD: begin
          if (edge_det[i] && iAck[i]) begin
            data_d[i*pWIDTH +: pWIDTH]    = count_q;
            overrun_d[i]                  = 1'b0;
          end else if (edge_det[i]) begin
            overrun_d[i]                  = 1'b1;
          end else if (iAck[i]) begin
            state_d[i]                    = IDLE;
            overrun_d[i]                  = 1'b0;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < pCHANNELS; i++) ready[i] = (state_q[i] == HELD);
  end

  // Lowest-index ready channel wins; scanning downward leaves the smallest index last.
  always_comb begin
    sel_idx   = '0;
    sel_valid = |ready;
    for (int i = pCHANNELS - 1; i >= 0; i--) begin
      if (ready[i]) sel_idx = SELW'(i);
    end
  end

  assign oCount    = count_q;
  assign oReady    = ready;
  assign oOverrun  = overrun_q;
  assign oData     = data_q;
  assign oSelValid = sel_valid;
  assign oSel      = sel_idx;
  assign oSelData  = sel_valid ? data_q[int'(sel_idx)*pWIDTH +: pWIDTH] : '0;

endmodule

// File: tb/tb_timestamp_capture_multi.sv
// Scoreboard bench for timestamp_capture_multi: an event-level reference model predicts every cycle,
// a monitor pops and compares at the falling edge; an 8-bit instance exercises counter wrap.
module tb_timestamp_capture_multi;

  localparam int CH = 4;
  localparam int W  = 64;
  localparam int SY = 2;

  logic          iCLKd = 1'b0;
  logic          rstA;
  logic          iEnable;
  logic          iClear;
  logic [CH-1:0] iLatch;
  logic [CH-1:0] iAck;

  logic [W-1:0]    oCount;
  logic [CH-1:0]   oReady;
  logic [CH-1:0]   oOverrun;
  logic [CH*W-1:0] oData;
  logic            oSelValid;
  logic [1:0]      oSel;
  logic [W-1:0]    oSelData;

  logic [7:0] w8_count;
  logic       w8_ready;
  logic       w8_overrun;
  logic [7:0] w8_data;
  logic       w8_sel_valid;
  logic       w8_sel;
  logic [7:0] w8_sel_data;

  always #5 iCLKd = ~iCLKd;

  timestamp_capture_multi #(.pCHANNELS(CH), .pWIDTH(W), .pSYNC(SY)) dut (
    .iCLKd(iCLKd), .rstA(rstA), .iEnable(iEnable), .iClear(iClear),
    .iLatch(iLatch), .iAck(iAck), .oCount(oCount), .oReady(oReady),
    .oOverrun(oOverrun), .oData(oData), .oSelValid(oSelValid),
    .oSel(oSel), .oSelData(oSelData)
  );

  timestamp_capture_multi #(.pCHANNELS(1), .pWIDTH(8), .pSYNC(SY)) dut8 (
    .iCLKd(iCLKd), .rstA(rstA), .iEnable(iEnable), .iClear(iClear),
    .iLatch(1'b0), .iAck(1'b0), .oCount(w8_count), .oReady(w8_ready),
    .oOverrun(w8_overrun), .oData(w8_data), .oSelValid(w8_sel_valid),
    .oSel(w8_sel), .oSelData(w8_sel_data)
  );

  typedef struct {
    logic [W-1:0]    count;
    logic [CH-1:0]   ready;
    logic [CH-1:0]   overrun;
    logic [CH*W-1:0] data;
    logic            selv;
    logic [1:0]      sel;
    logic [W-1:0]    seldata;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  logic [W-1:0]    m_count;
  logic [CH-1:0]   m_ready, m_over, m_last, m_rise, m_act;
  logic [CH*W-1:0] m_data;
  logic [CH-1:0]   m_dly[$];
  exp_t            m_e;
  exp_t            mon_e;

  task automatic checkOutput(input string name, input logic [CH*W-1:0] act, input logic [CH*W-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: a rise sampled at clock k acts on its channel at clock k+SY.
  always @(posedge iCLKd or posedge rstA) begin
    if (rstA) begin
      m_count = '0;
      m_ready = '0;
      m_over  = '0;
      m_last  = '0;
      m_data  = '0;
      m_dly.delete();
      for (int k = 0; k < SY; k++) m_dly.push_back('0);
      sb_q.delete();
    end else begin
      m_rise = iLatch & ~m_last;
      m_last = iLatch;
      m_act  = m_dly.pop_front();
      m_dly.push_back(m_rise);
      for (int c = 0; c < CH; c++) begin
        if (m_act[c]) begin
          if (!m_ready[c]) begin
            m_ready[c] = 1'b1;
            m_data[c*W +: W] = m_count;
          end else if (iAck[c]) begin
            m_data[c*W +: W] = m_count;
            m_over[c] = 1'b0;
          end else begin
            m_over[c] = 1'b1;
          end
        end else if (m_ready[c] && iAck[c]) begin
          m_ready[c] = 1'b0;
          m_over[c]  = 1'b0;
        end
      end
      if (iClear) m_count = '0;
      else if (iEnable) m_count = m_count + 64'd1;
      m_e.count   = m_count;
      m_e.ready   = m_ready;
      m_e.overrun = m_over;
      m_e.data    = m_data;
      m_e.selv    = |m_ready;
      m_e.sel     = '0;
      for (int c = CH - 1; c >= 0; c--) if (m_ready[c]) m_e.sel = 2'(c);
      m_e.seldata = m_e.selv ? m_data[int'(m_e.sel)*W +: W] : '0;
      sb_q.push_back(m_e);
    end
  end

  // Monitor: one expected snapshot per clock, popped away from the active edge.
  always @(negedge iCLKd) begin
    if (rstA) begin
      checkOutput("rst_count", oCount, '0);
      checkOutput("rst_ready", oReady, '0);
      checkOutput("rst_data", oData, '0);
      checkOutput("rst_selv", oSelValid, '0);
    end else if (sb_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL scoreboard_empty: got no expected entry, required one at %0t", $time);
    end else begin
      mon_e = sb_q.pop_front();
      checkOutput("count", oCount, mon_e.count);
      checkOutput("ready", oReady, mon_e.ready);
      checkOutput("overrun", oOverrun, mon_e.overrun);
      checkOutput("data", oData, mon_e.data);
      checkOutput("sel_valid", oSelValid, mon_e.selv);
      checkOutput("sel", oSel, mon_e.sel);
      checkOutput("sel_data", oSelData, mon_e.seldata);
      checkOutput("count8", w8_count, mon_e.count[7:0]);
      checkOutput("flags8", {w8_ready, w8_overrun}, '0);
    end
  end

  task automatic applyStimulus(input logic [CH-1:0] latch, input logic [CH-1:0] ack,
                               input logic clr, input logic en);
    iLatch  = latch;
    iAck    = ack;
    iClear  = clr;
    iEnable = en;
    @(negedge iCLKd);
    #1;
  endtask

  task automatic runUntil(input logic [W-1:0] target);
    int guard = 0;
    while (m_count != target && guard < 3000) begin
      applyStimulus('0, '0, 1'b0, 1'b1);
      guard++;
    end
    checkOutput("run_until_reached", m_count, target);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_count"}, oCount, '0);
    checkOutput({tag, "_ready"}, oReady, '0);
    checkOutput({tag, "_overrun"}, oOverrun, '0);
    checkOutput({tag, "_data"}, oData, '0);
    checkOutput({tag, "_selv"}, oSelValid, '0);
    checkOutput({tag, "_sel"}, oSel, '0);
    checkOutput({tag, "_seldata"}, oSelData, '0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL timeout: simulation did not complete, required finish before %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [W-1:0] c0;
    rstA    = 1'b1;
    iEnable = 1'b0;
    iClear  = 1'b0;
    iLatch  = '0;
    iAck    = '0;
    #12;
    checkAllZero("reset");
    @(negedge iCLKd);
    #1;
    rstA = 1'b0;

    // Counter run, then clear and restart from zero.
    repeat (6) applyStimulus('0, '0, 1'b0, 1'b1);
    applyStimulus('0, '0, 1'b1, 1'b1);
    checkOutput("clear_zero", oCount, '0);
    repeat (3) applyStimulus('0, '0, 1'b0, 1'b1);
    checkOutput("count_after_clear", oCount, 64'd3);

    // Single capture on channel 1.
    runUntil(64'd98);
    repeat (3) applyStimulus(4'b0010, '0, 1'b0, 1'b1);
    checkOutput("single_ready", oReady, 4'b0010);
    checkOutput("single_data", oData[1*W +: W], 64'd100);
    checkOutput("single_selv", oSelValid, 1'b1);
    checkOutput("single_sel", oSel, 2'd1);
    checkOutput("single_seldata", oSelData, 64'd100);

    // Second edge while held sets the sticky overrun; ack releases.
    repeat (2) applyStimulus(4'b0000, '0, 1'b0, 1'b1);
    repeat (3) applyStimulus(4'b0010, '0, 1'b0, 1'b1);
    checkOutput("overrun_flag", oOverrun[1], 1'b1);
    checkOutput("overrun_data", oData[1*W +: W], 64'd100);
    applyStimulus(4'b0010, 4'b0010, 1'b0, 1'b1);
    checkOutput("ack_ready", oReady[1], 1'b0);
    checkOutput("ack_overrun", oOverrun[1], 1'b0);

    // Ack and edge in the same cycle on channel 2.
    runUntil(64'd498);
    repeat (3) applyStimulus(4'b0100, '0, 1'b0, 1'b1);
    checkOutput("ch2_hold", oData[2*W +: W], 64'd500);
    repeat (2) applyStimulus(4'b0000, '0, 1'b0, 1'b1);
    c0 = m_count;
    repeat (2) applyStimulus(4'b0100, '0, 1'b0, 1'b1);
    applyStimulus(4'b0100, 4'b0100, 1'b0, 1'b1);
    checkOutput("simul_ready", oReady[2], 1'b1);
    checkOutput("simul_overrun", oOverrun[2], 1'b0);
    checkOutput("simul_data", oData[2*W +: W], c0 + 64'd2);

    // Arbitration: lowest ready index wins.
    repeat (3) applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b1);
    repeat (3) applyStimulus(4'b1000, '0, 1'b0, 1'b1);
    checkOutput("arb_only3", oSel, 2'd3);
    repeat (3) applyStimulus(4'b1001, '0, 1'b0, 1'b1);
    checkOutput("arb_both_sel", oSel, 2'd0);
    applyStimulus(4'b1001, 4'b0001, 1'b0, 1'b1);
    checkOutput("arb_after_ack0", oSel, 2'd3);
    checkOutput("arb_after_ack0_v", oSelValid, 1'b1);
    applyStimulus(4'b1001, 4'b1000, 1'b0, 1'b1);
    checkOutput("arb_none_v", oSelValid, 1'b0);
    checkOutput("arb_none_sel", oSel, 2'd0);
    checkOutput("arb_none_data", oSelData, '0);

    // Asynchronous reset mid-operation, latch held high through release.
    repeat (2) applyStimulus(4'b0000, '0, 1'b0, 1'b1);
    runUntil(64'd998);
    repeat (3) applyStimulus(4'b0001, '0, 1'b0, 1'b1);
    checkOutput("pre_reset_data", oData[0 +: W], 64'd1000);
    #2;
    rstA = 1'b1;
    #1;
    checkAllZero("async_reset");
    @(negedge iCLKd);
    #1;
    rstA = 1'b0;
    repeat (2) applyStimulus(4'b0001, '0, 1'b0, 1'b1);
    checkOutput("release_not_yet", oReady, 4'b0000);
    applyStimulus(4'b0001, '0, 1'b0, 1'b1);
    checkOutput("release_capture", oReady, 4'b0001);
    checkOutput("release_data", oData[0 +: W], 64'd2);

    // Randomised traffic; levels change at most once per clock.
    for (int n = 0; n < 600; n++) begin
      logic [CH-1:0] flip, ack;
      flip = '0;
      ack  = '0;
      for (int c = 0; c < CH; c++) begin
        flip[c] = ($urandom_range(0, 3) == 0);
        ack[c]  = ($urandom_range(0, 3) == 0);
      end
      applyStimulus(iLatch ^ flip, ack, ($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0));
    end

    // Uninterrupted run so the 8-bit instance wraps through all-ones.
    applyStimulus('0, 4'b1111, 1'b1, 1'b1);
    repeat (300) applyStimulus('0, '0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
